// File: rtl/cms_pix28_package.sv
// -----------------------------------------------------------------------------
// cms_pix28_package
// Shared types and default constants for the event-toggle capture block.
//   evt_state_t  : capture FSM states (idle / one-cycle arm / run)
//   evt_record_t : FIFO record layout {up, dn, ts} at the default TS width
//   *_DEF        : default values for TS_WIDTH, CNT_WIDTH, FIFO_DEPTH
// -----------------------------------------------------------------------------
package cms_pix28_package;

   localparam int TS_WIDTH_DEF   = 16;
   localparam int CNT_WIDTH_DEF  = 16;
   localparam int FIFO_DEPTH_DEF = 16;

   typedef enum logic [1:0] {
      EVT_IDLE = 2'd0,
      EVT_ARM  = 2'd1,
      EVT_RUN  = 2'd2
   } evt_state_t;

   typedef struct packed {
      logic                    up;
      logic                    dn;
      logic [TS_WIDTH_DEF-1:0] ts;
   } evt_record_t;

endpackage

// File: rtl/evt_sync_fifo.sv
// -----------------------------------------------------------------------------
// evt_sync_fifo
// First-word-fall-through synchronous FIFO. The head word is presented on
// rd_data whenever the FIFO is not empty (zero while empty).
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   clr                : synchronous flush (pointers to zero), beats wr/rd
//   wr_en, wr_data     : push request and data
//   rd_en              : pop request (ignored while empty)
//   rd_data            : head word
//   empty, full, level : status, level = occupancy
//   wr_drop            : push refused because full with no pop this cycle
// -----------------------------------------------------------------------------
module evt_sync_fifo #(
   parameter int DATA_W = 18,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     wr_drop
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr_q;
   logic [AW:0]       rd_ptr_q;
   logic              rd_ok;
   logic              wr_ok;

   // Pointers carry one extra MSB so full and empty are distinguishable.
   assign level = wr_ptr_q - rd_ptr_q;
   assign empty = (level == '0);
   assign full  = (level == (AW + 1)'(DEPTH));

   // A pop frees a slot in the same cycle, so a push into a full FIFO
   // is still accepted when it coincides with a pop.
   assign rd_ok   = rd_en & ~empty;
   assign wr_ok   = wr_en & (~full | rd_ok);
   assign wr_drop = wr_en & ~wr_ok & ~clr;

   assign rd_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage is not reset; rd_data is masked while empty instead.
   always_ff @(posedge clk) begin
      if (wr_ok && !clr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/event_toggle_capture.sv
// -----------------------------------------------------------------------------
// event_toggle_capture
// Counts and time-stamps DUT events arriving as level toggles on the up/dn
// event lines of the active firmware slot. Every level change is one event.
// Records {up, dn, ts} go into a FWFT FIFO drained by the readout logic.
//
// Build option: define CMS_PIX28_EVENT_GLITCH_FILTER_EN to insert a 2-cycle
// stability filter on each toggle line (single-cycle pulses ignored, event
// latency N+2 instead of N+1).
//
// Ports:
//   fw_pl_clk1      : fabric clock
//   fw_rst_n        : asynchronous active-low reset
//   enable          : capture enable (level)
//   clear           : 1-cycle synchronous clear of counters, ts, FIFO, overflow
//   up/dn_event_toggle : registered toggle lines
//   up_count/dn_count  : saturating event counters
//   fifo_rd_en      : pop request
//   fifo_rd_data    : FIFO head {up, dn, ts}
//   fifo_empty/full/level : FIFO status
//   overflow        : sticky, a record was dropped on a full FIFO
// -----------------------------------------------------------------------------
module event_toggle_capture
   import cms_pix28_package::*;
#(
   parameter int TS_WIDTH   = TS_WIDTH_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                          fw_pl_clk1,
   input  logic                          fw_rst_n,
   input  logic                          enable,
   input  logic                          clear,
   input  logic                          up_event_toggle,
   input  logic                          dn_event_toggle,
   output logic [CNT_WIDTH-1:0]          up_count,
   output logic [CNT_WIDTH-1:0]          dn_count,
   input  logic                          fifo_rd_en,
   output logic [TS_WIDTH+1:0]           fifo_rd_data,
   output logic                          fifo_empty,
   output logic                          fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);
   localparam int REC_W = TS_WIDTH + 2;

   evt_state_t           state_q;
   evt_state_t           state_d;
   logic                 arm_load;
   logic                 run_det;
   logic                 up_lvl;
   logic                 dn_lvl;
   logic                 prev_up_q;
   logic                 prev_dn_q;
   logic                 ev_up;
   logic                 ev_dn;
   logic [TS_WIDTH-1:0]  ts_q;
   logic [CNT_WIDTH-1:0] up_cnt_q;
   logic [CNT_WIDTH-1:0] dn_cnt_q;
   logic                 fifo_wr_en;
   logic                 fifo_drop;
   logic [REC_W-1:0]     rec_data;
   logic                 ovf_q;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic              inc);
      return (inc && (v != '1)) ? v + 1'b1 : v;
   endfunction

`ifdef CMS_PIX28_EVENT_GLITCH_FILTER_EN
   // A new level is accepted once it was seen in the previous cycle and is
   // still present now; otherwise the last accepted level is held.
   logic up_s1_q;
   logic dn_s1_q;
   logic up_filt_q;
   logic dn_filt_q;

   assign up_lvl = (up_event_toggle == up_s1_q) ? up_event_toggle : up_filt_q;
   assign dn_lvl = (dn_event_toggle == dn_s1_q) ? dn_event_toggle : dn_filt_q;

   always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         up_s1_q   <= 1'b0;
         dn_s1_q   <= 1'b0;
         up_filt_q <= 1'b0;
         dn_filt_q <= 1'b0;
      end else begin
         up_s1_q   <= up_event_toggle;
         dn_s1_q   <= dn_event_toggle;
         up_filt_q <= up_lvl;
         dn_filt_q <= dn_lvl;
      end
   end
`else
   assign up_lvl = up_event_toggle;
   assign dn_lvl = dn_event_toggle;
`endif

   // FSM state register
   always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
      if (!fw_rst_n) state_q <= EVT_IDLE;
      else           state_q <= state_d;
   end

   // FSM next state; clear restarts through ARM so prev is reloaded
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = enable ? EVT_ARM : EVT_IDLE;
      end else begin
         case (state_q)
            EVT_IDLE: if (enable) state_d = EVT_ARM;
            EVT_ARM:  state_d = enable ? EVT_RUN : EVT_IDLE;
            EVT_RUN:  if (!enable) state_d = EVT_IDLE;
            default:  state_d = EVT_IDLE;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      arm_load = 1'b0;
      run_det  = 1'b0;
      case (state_q)
         EVT_ARM: arm_load = 1'b1;
         EVT_RUN: run_det  = 1'b1;
         default: ;
      endcase
   end

   assign ev_up = run_det & (up_lvl ^ prev_up_q);
   assign ev_dn = run_det & (dn_lvl ^ prev_dn_q);

   // Events coinciding with clear are discarded.
   assign fifo_wr_en = (ev_up | ev_dn) & ~clear;
   assign rec_data   = {ev_up, ev_dn, ts_q};

   always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         prev_up_q <= 1'b0;
         prev_dn_q <= 1'b0;
         ts_q      <= '0;
         up_cnt_q  <= '0;
         dn_cnt_q  <= '0;
      end else if (clear) begin
         ts_q     <= '0;
         up_cnt_q <= '0;
         dn_cnt_q <= '0;
      end else if (arm_load) begin
         // Seed prev from the current level so arming never looks like an edge.
         prev_up_q <= up_lvl;
         prev_dn_q <= dn_lvl;
         ts_q      <= '0;
      end else if (run_det) begin
         prev_up_q <= up_lvl;
         prev_dn_q <= dn_lvl;
         ts_q      <= ts_q + 1'b1;
         up_cnt_q  <= sat_inc(up_cnt_q, ev_up);
         dn_cnt_q  <= sat_inc(dn_cnt_q, ev_dn);
      end
   end

   always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
      if (!fw_rst_n)      ovf_q <= 1'b0;
      else if (clear)     ovf_q <= 1'b0;
      else if (fifo_drop) ovf_q <= 1'b1;
   end

   evt_sync_fifo #(
      .DATA_W (REC_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (fw_pl_clk1),
      .rst_n   (fw_rst_n),
      .clr     (clear),
      .wr_en   (fifo_wr_en),
      .wr_data (rec_data),
      .rd_en   (fifo_rd_en),
      .rd_data (fifo_rd_data),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .level   (fifo_level),
      .wr_drop (fifo_drop)
   );

   assign up_count = up_cnt_q;
   assign dn_count = dn_cnt_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_event_toggle_capture.sv
module tb_event_toggle_capture;
   import cms_pix28_package::*;

   localparam int TSW   = 16;
   localparam int CW    = 16;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int RW    = TSW + 2;
   localparam int CMAX  = (1 << CW) - 1;
`ifdef CMS_PIX28_EVENT_GLITCH_FILTER_EN
   localparam int HOLD  = 2;
`else
   localparam int HOLD  = 1;
`endif
   localparam int M_IDLE = 0;
   localparam int M_ARM  = 1;
   localparam int M_RUN  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          clear = 1'b0;
   logic          up_t = 1'b0;
   logic          dn_t = 1'b0;
   logic          rd_en = 1'b0;
   logic [CW-1:0] up_count;
   logic [CW-1:0] dn_count;
   logic [RW-1:0] fifo_rd_data;
   logic          fifo_empty;
   logic          fifo_full;
   logic [LW-1:0] fifo_level;
   logic          overflow;

   always #5 clk = ~clk;

   event_toggle_capture dut (
      .fw_pl_clk1      (clk),
      .fw_rst_n        (rst_n),
      .enable          (enable),
      .clear           (clear),
      .up_event_toggle (up_t),
      .dn_event_toggle (dn_t),
      .up_count        (up_count),
      .dn_count        (dn_count),
      .fifo_rd_en      (rd_en),
      .fifo_rd_data    (fifo_rd_data),
      .fifo_empty      (fifo_empty),
      .fifo_full       (fifo_full),
      .fifo_level      (fifo_level),
      .overflow        (overflow)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] rec(input bit u, input bit d, input int ts);
      evt_record_t r;
      r.up = u;
      r.dn = d;
      r.ts = TSW'(ts);
      return r;
   endfunction

   // ---------------- behavioural reference model ----------------
   int            m_mode;
   logic [TSW-1:0] m_ts;
   int            m_up;
   int            m_dn;
   bit            m_ovf;
   bit            m_prev_up;
   bit            m_prev_dn;
   logic [RW-1:0] m_q[$];
`ifdef CMS_PIX28_EVENT_GLITCH_FILTER_EN
   bit            m_last_up;
   bit            m_last_dn;
   bit            m_acc_up;
   bit            m_acc_dn;
`endif

   task automatic model_reset();
      m_mode = M_IDLE; m_ts = '0; m_up = 0; m_dn = 0; m_ovf = 0;
      m_prev_up = 0; m_prev_dn = 0;
      m_q.delete();
`ifdef CMS_PIX28_EVENT_GLITCH_FILTER_EN
      m_last_up = 0; m_last_dn = 0; m_acc_up = 0; m_acc_dn = 0;
`endif
   endtask

   // Advance the model by one clock edge using the inputs present now.
   task automatic model_edge();
      bit lu, ld, eu, ed, want, pop, was_full;
      logic [RW-1:0] r;
      want = 0;
      r = '0;
`ifdef CMS_PIX28_EVENT_GLITCH_FILTER_EN
      lu = (up_t == m_last_up) ? up_t : m_acc_up;
      ld = (dn_t == m_last_dn) ? dn_t : m_acc_dn;
      m_acc_up = lu; m_acc_dn = ld;
      m_last_up = up_t; m_last_dn = dn_t;
`else
      lu = up_t;
      ld = dn_t;
`endif
      if (clear) begin
         m_ts = '0; m_up = 0; m_dn = 0; m_ovf = 0;
         m_q.delete();
         m_mode = enable ? M_ARM : M_IDLE;
      end else begin
         if (m_mode == M_IDLE) begin
            if (enable) m_mode = M_ARM;
         end else if (m_mode == M_ARM) begin
            m_prev_up = lu; m_prev_dn = ld; m_ts = '0;
            m_mode = enable ? M_RUN : M_IDLE;
         end else begin
            eu = (lu != m_prev_up);
            ed = (ld != m_prev_dn);
            m_prev_up = lu; m_prev_dn = ld;
            if (eu || ed) begin
               want = 1;
               r = {eu, ed, m_ts};
            end
            if (eu && m_up < CMAX) m_up++;
            if (ed && m_dn < CMAX) m_dn++;
            m_ts = m_ts + 1'b1;
            if (!enable) m_mode = M_IDLE;
         end
         was_full = (m_q.size() == DEPTH);
         pop = rd_en && (m_q.size() != 0);
         if (pop) void'(m_q.pop_front());
         if (want) begin
            if (!was_full || pop) m_q.push_back(r);
            else m_ovf = 1;
         end
      end
   endtask

   task automatic compare_model();
      logic [RW-1:0] hd;
      hd = (m_q.size() != 0) ? m_q[0] : '0;
      chk("up_count",     32'(up_count),     32'(m_up));
      chk("dn_count",     32'(dn_count),     32'(m_dn));
      chk("fifo_level",   32'(fifo_level),   32'(m_q.size()));
      chk("fifo_empty",   32'(fifo_empty),   32'(m_q.size() == 0));
      chk("fifo_full",    32'(fifo_full),    32'(m_q.size() == DEPTH));
      chk("fifo_rd_data", 32'(fifo_rd_data), 32'(hd));
      chk("overflow",     32'(overflow),     32'(m_ovf));
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      else       model_reset();
      @(negedge clk);
      compare_model();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " up_count"},   32'(up_count),     32'd0);
      chk({tag, " dn_count"},   32'(dn_count),     32'd0);
      chk({tag, " fifo_empty"}, 32'(fifo_empty),   32'd1);
      chk({tag, " fifo_full"},  32'(fifo_full),    32'd0);
      chk({tag, " fifo_level"}, 32'(fifo_level),   32'd0);
      chk({tag, " rd_data"},    32'(fifo_rd_data), 32'd0);
      chk({tag, " overflow"},   32'(overflow),     32'd0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int            n;
      bit            en, clr, up, dn, rd;
      int            exp_up, exp_dn, exp_lvl;
      logic [RW-1:0] exp_data;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input int n, input bit en, input bit clr, input bit up,
                               input bit dn, input bit rd, input int eu, input int ed,
                               input int el, input logic [RW-1:0] d);
      vec_t v;
      v.n = n; v.en = en; v.clr = clr; v.up = up; v.dn = dn; v.rd = rd;
      v.exp_up = eu; v.exp_dn = ed; v.exp_lvl = el; v.exp_data = d;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int rd_pct;

      model_reset();
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;

`ifndef CMS_PIX28_EVENT_GLITCH_FILTER_EN
      //            n  en clr up dn rd  up dn lvl data
      tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0, '0));             // IDLE -> ARM
      tbl.push_back(mk(1, 1, 0, 1, 1, 0, 0, 0, 0, '0));             // ARM -> RUN
      tbl.push_back(mk(5, 1, 0, 1, 1, 0, 0, 0, 0, '0));             // ts 0..4 quiet
      tbl.push_back(mk(1, 1, 0, 0, 1, 0, 1, 0, 1, rec(1, 0, 5)));   // up toggle ts5
      tbl.push_back(mk(3, 1, 0, 0, 1, 0, 1, 0, 1, rec(1, 0, 5)));
      tbl.push_back(mk(1, 1, 0, 1, 1, 0, 2, 0, 2, rec(1, 0, 5)));   // ts9
      tbl.push_back(mk(10, 1, 0, 1, 1, 0, 2, 0, 2, rec(1, 0, 5)));
      tbl.push_back(mk(1, 1, 0, 0, 1, 0, 3, 0, 3, rec(1, 0, 5)));   // ts20
      tbl.push_back(mk(1, 1, 0, 0, 1, 1, 3, 0, 2, rec(1, 0, 9)));   // pops
      tbl.push_back(mk(1, 1, 0, 0, 1, 1, 3, 0, 1, rec(1, 0, 20)));
      tbl.push_back(mk(1, 1, 0, 0, 1, 1, 3, 0, 0, '0));
      tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, '0));             // clear -> ARM
      tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, '0));             // ARM -> RUN
      tbl.push_back(mk(7, 1, 0, 0, 1, 0, 0, 0, 0, '0));             // ts 0..6
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 1, rec(1, 1, 7)));   // both at ts7
      tbl.push_back(mk(1, 1, 0, 1, 0, 1, 1, 1, 0, '0));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, 0, '0));             // last RUN cycle
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, '0));             // frozen
      tbl.push_back(mk(3, 0, 0, 1, 1, 0, 1, 1, 0, '0));
      tbl.push_back(mk(2, 1, 0, 1, 0, 0, 1, 1, 0, '0));             // re-arm, no clear
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 2, 1, 1, rec(1, 0, 0)));

      foreach (tbl[k]) begin
         enable = tbl[k].en; clear = tbl[k].clr; up_t = tbl[k].up;
         dn_t = tbl[k].dn; rd_en = tbl[k].rd;
         repeat (tbl[k].n) tick();
         chk($sformatf("vec%0d up_count", k), 32'(up_count),     32'(tbl[k].exp_up));
         chk($sformatf("vec%0d dn_count", k), 32'(dn_count),     32'(tbl[k].exp_dn));
         chk($sformatf("vec%0d level", k),    32'(fifo_level),   32'(tbl[k].exp_lvl));
         chk($sformatf("vec%0d rd_data", k),  32'(fifo_rd_data), 32'(tbl[k].exp_data));
      end
      rd_en = 1'b0;
`endif

      // Overflow: 20 up events with no reads
      enable = 1'b1; clear = 1'b1; rd_en = 1'b0;
      tick();
      clear = 1'b0;
      tick();
      for (int i = 0; i < 20; i++) begin
         up_t = ~up_t;
         repeat (HOLD) tick();
      end
      chk("ovf fifo_full",  32'(fifo_full),  32'd1);
      chk("ovf fifo_level", 32'(fifo_level), 32'd16);
      chk("ovf overflow",   32'(overflow),   32'd1);
      chk("ovf up_count",   32'(up_count),   32'd20);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("ovf rec%0d", i), 32'(fifo_rd_data), 32'(rec(1, 0, i * HOLD + HOLD - 1)));
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
      end
      chk("ovf drained empty", 32'(fifo_empty), 32'd1);
      chk("ovf sticky",        32'(overflow),   32'd1);

      // Write on a full FIFO together with a pop
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         up_t = ~up_t;
         repeat (HOLD) tick();
      end
      chk("fullpop pre level", 32'(fifo_level), 32'd16);
      chk("fullpop pre ovf",   32'(overflow),   32'd0);
      up_t = ~up_t;
      repeat (HOLD - 1) tick();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("fullpop level",    32'(fifo_level),   32'd16);
      chk("fullpop overflow", 32'(overflow),     32'd0);
      chk("fullpop up_count", 32'(up_count),     32'd17);
      chk("fullpop head",     32'(fifo_rd_data), 32'(rec(1, 0, HOLD + HOLD - 1)));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk_reset_vals("clear");
      tick();

`ifdef CMS_PIX28_EVENT_GLITCH_FILTER_EN
      // Single-cycle pulse on dn is filtered out
      dn_t = 1'b1;
      tick();
      dn_t = 1'b0;
      repeat (3) tick();
      chk("glitch dn_count", 32'(dn_count),   32'd0);
      chk("glitch level",    32'(fifo_level), 32'd0);
      // Stable change: record visible two cycles after the toggle
      dn_t = 1'b1;
      tick();
      chk("filt N+1 level", 32'(fifo_level), 32'd0);
      tick();
      chk("filt N+2 level",    32'(fifo_level),              32'd1);
      chk("filt N+2 dn_count", 32'(dn_count),                32'd1);
      chk("filt N+2 flags",    32'(fifo_rd_data[RW-1:TSW]),  32'd1);
      tick();
      chk("filt single event", 32'(dn_count), 32'd1);
`endif

      // Asynchronous reset in the middle of RUN
      for (int i = 0; i < 2; i++) begin
         up_t = ~up_t;
         repeat (HOLD) tick();
      end
      chk("prerst up_count", 32'(up_count), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();

      // Randomized traffic against the model
      rd_pct = 30;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            case ($urandom_range(0, 2))
               0: rd_pct = 0;
               1: rd_pct = 20;
               default: rd_pct = 60;
            endcase
         end
         if ($urandom_range(0, 99) < 3) enable = ~enable;
         clear = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 99) < 25) up_t = ~up_t;
         if ($urandom_range(0, 99) < 25) dn_t = ~dn_t;
         rd_en = ($urandom_range(0, 99) < rd_pct);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/event_toggle_capture.md
Name: event_toggle_capture

Overview:
- Downstream consumer of the DUT event-toggle inputs, after they pass through the IOB input flops and the firmware mux.
- Takes fw_up_event_toggle[k] and fw_dn_event_toggle[k] for the active firmware slot.
- Each level change on a toggle line is one DUT event. The block counts events per direction and time-stamps them.
- Records are buffered in a small sync FIFO, drained by the firmware register/readout logic.

Parameters:
- TS_WIDTH, 16, timestamp counter width (free-running while armed, wraps).
- CNT_WIDTH, 16, width of the saturating up/dn event counters.
- FIFO_DEPTH, 16, record FIFO depth; power of two, >=4.

Ports:
- fw_pl_clk1  in  1  fabric clock (400 MHz), same domain as the IOB flops.
- fw_rst_n  in  1  asynchronous active-low reset.
- enable  in  1  capture enable, level.
- clear  in  1  synchronous single-cycle clear of counters, timestamp, FIFO and overflow.
- up_event_toggle  in  1  registered up-event toggle line.
- dn_event_toggle  in  1  registered dn-event toggle line.
- up_count  out  CNT_WIDTH  number of up events since clear/reset.
- dn_count  out  CNT_WIDTH  number of dn events since clear/reset.
- fifo_rd_en  in  1  pop request.
- fifo_rd_data  out  TS_WIDTH+2  record at the FIFO head: {up, dn, timestamp}.
- fifo_empty  out  1  FIFO empty.
- fifo_full  out  1  FIFO full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  sticky; set when a record was dropped.

Behaviour:
- Reset (async, fw_rst_n=0):
  - State IDLE.
  - Counters, timestamp, prev-toggle registers, FIFO pointers and overflow all 0.
  - fifo_empty=1, fifo_full=0, fifo_level=0, fifo_rd_data=0.
- FSM:
  - IDLE: no detection; timestamp held. enable=1 -> ARM.
  - ARM (exactly 1 cycle): load prev_up/prev_dn from the inputs, so no spurious event on arming; timestamp <= 0. Next state RUN if enable=1, else IDLE.
  - RUN:
    - ev_up = up_event_toggle ^ prev_up; ev_dn likewise. prev registers update every cycle.
    - Timestamp increments every cycle, wraps from 2^TS_WIDTH-1 to 0.
    - enable=0 -> IDLE.
- clear=1:
  - Highest priority after reset.
  - Zeroes counters, timestamp, FIFO pointers and overflow.
  - Next state ARM if enable=1, else IDLE. Events in the clear cycle are discarded.
- Event handling (RUN only):
  - If ev_up|ev_dn, write record {ev_up, ev_dn, ts}, where ts is the timestamp value in the detection cycle.
  - Simultaneous up and dn events produce one record with both bits set.
  - Each counter increments by 1 on its own event and saturates at all-ones (no wrap).
- Latency:
  - Toggle present at the input in cycle N: record and counter updates are visible at cycle N+1.
  - fifo_empty drops at N+1 if the FIFO was empty.
- FIFO:
  - First-word-fall-through: fifo_rd_data shows the head whenever !fifo_empty.
  - fifo_rd_en while empty is ignored.
  - Write while full with no pop in the same cycle: record dropped, overflow<=1 (sticky until clear/reset). Counters still increment.
  - Write while full with a pop in the same cycle: both accepted, level unchanged.
  - Write and pop on empty: the write is accepted and the pop is ignored; level becomes 1.
  - Pointers wrap modulo FIFO_DEPTH. Level = wr_ptr - rd_ptr using an extra MSB.
- Mid-operation:
  - enable dropping freezes counters and timestamp; FIFO contents stay readable.
  - Re-enabling passes through ARM; counters are not cleared.

Optional Feature:
- Macro: CMS_PIX28_EVENT_GLITCH_FILTER_EN.
- Defined:
  - Each toggle line passes a 2-stage stability filter. A new level is accepted only after being stable for 2 consecutive cycles.
  - Single-cycle pulses are ignored (no event).
  - Event latency becomes N+2.
  - ARM loads prev from the filtered value.
- Undefined: raw detection as above, latency N+1.

Decomposition:
- Into cms_pix28_package:
  - typedef enum logic [1:0] {EVT_IDLE, EVT_ARM, EVT_RUN} evt_state_t.
  - Packed struct evt_record_t {logic up; logic dn; logic [TS_WIDTH-1:0] ts}.
  - Default constants for TS_WIDTH, CNT_WIDTH, FIFO_DEPTH.
- Sub-module: evt_sync_fifo, a parameterised FWFT sync FIFO with full/empty/level, same clock and reset.
- Top holds the FSM, toggle detection, filter, counters and timestamp.

Test Plan:
- Arm with both lines at 1, hold 10 cycles -> no records, up_count=0, dn_count=0.
- Up line toggles 3 times at RUN cycles 5, 9, 20 -> 3 records {1,0,5}, {1,0,9}, {1,0,20}; up_count=3, dn_count=0; each record appears 1 cycle after its toggle.
- Both lines toggle in the same cycle at ts=7 -> single record {1,1,7}; both counts increment by 1.
- 20 up toggles with no reads, FIFO_DEPTH=16 -> fifo_full=1, fifo_level=16, overflow=1, up_count=20; first 16 records retained in order.
- FIFO full plus one event in the same cycle as fifo_rd_en=1 -> record accepted, level stays 16, overflow stays 0; clear -> level 0, counts 0, overflow 0.
- Glitch filter on, 1-cycle pulse on dn -> no event. 3-cycle-stable dn change -> one event, record at detection+2. Async reset mid-RUN -> all outputs return to reset values immediately.
